operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Register-read stage of the dual-issue (upper/lower lane) pipeline; reader side of the GPR file.
//  Reads four source operands of the decoded 64-bit bundle from the GPR file.
//  Bypasses them from the exec, mem and load-return paths, and registers them towards exec.
//  Detects load-use hazards against the bundle it is handing to exec and inserts one bubble.
// PARAMETERS
//  XLEN      32   operand/data width
//  RIDX_W    5    register index width (32 GPRs)
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      sync reset, active-high
//  interlock           in   1      global freeze; all state holds
//  inst_from_dec       in   64     bundle: [63:32] upper inst, [31:0] lower inst
//  valid_from_dec      in   1      bundle valid
//  u_rs_from_dec       in   2*RIDX_W  upper sources {rs1,rs2}
//  u_rs_flag_from_dec  in   2      upper source-used flags
//  l_rs_from_dec       in   2*RIDX_W  lower sources {rs1,rs2}
//  l_rs_flag_from_dec  in   2      lower source-used flags
//  u_rt_from_dec       in   RIDX_W     upper destination register
//  u_rt_flag_from_dec  in   1          upper destination-written flag
//  l_rt_from_dec       in   RIDX_W     lower destination register
//  l_rt_flag_from_dec  in   1          lower destination-written flag
//  gpr_raddr           out  4*RIDX_W   {u_rs1,u_rs2,l_rs1,l_rs2}; comb, = dec sources
//  gpr_rdata           in   4*XLEN     same order; combinational GPR read
//  {u,l}_tdata_from_exec  in   XLEN    exec results
//  {u,l}_rt_from_exec     in   RIDX_W  exec destination registers
//  {u,l}_rt_flag_from_exec in  1       exec destination-written flags
//  inst_from_mem       in   64         bundle in mem stage
//  {u,l}_rt_from_mem   in   RIDX_W     mem destination registers
//  {u,l}_rt_flag_from_mem in 1         mem destination-written flags
//  l_tdata_from_mem    in   XLEN       lower non-load mem result
//  mem_doutb           in   64         load data [63:32] upper, [31:0] lower
//  stall_to_dec        out  1          comb; decoder holds its bundle this cycle
//  inst_to_exec        out  64     registered bundle (0 = bubble)
//  valid_to_exec       out  1      registered valid
//  {u,l}_rt_to_exec, {u,l}_rt_flag_to_exec  out  RIDX_W/1  registered destinations
//  {u,l}_opa_to_exec, {u,l}_opb_to_exec     out  XLEN      registered operands
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): every registered output 0, valid_to_exec 0; perf counters 0.
//  - Latency 1: bundle sampled at posedge, operands valid the following cycle.
//  - interlock=1: all registers hold; stall_to_dec driven as normal but has no effect.
//  - Load detection: opcode == 6'b010000 (upper [63:58], lower [31:26]).
//  - Hazard: valid_to_exec=1, a lane of inst_to_exec is a load with rt_flag set,
//    and that rt equals any flagged source of the valid incoming bundle.
//    On hazard: stall_to_dec=1; regs load bubble (inst 0, valid 0, flags 0).
//    The bubble removes the hazard next cycle, so a stall never lasts more than 1 cycle.
//  - Bypass per operand, highest priority first:
//    1. exec lower, 2. exec upper (only if that exec lane is not a load).
//    3. mem lower, 4. mem upper:
//       load lane -> matching mem_doutb half; lower non-load -> l_tdata_from_mem.
//       Upper non-load mem lane is not bypassed (its data has already retired via exec).
//    5. gpr_rdata.
//    A match needs the producer's rt_flag=1 and equal index; unflagged sources pass gpr_rdata.
//  - Lower lane must not source upper rt of the same bundle (decoder guarantees this).
//    This case is not checked here.
//  - Register 0 is not special-cased.
// CONFIGURATION
//  OPERAND_FETCH_PERF_EN defined: adds outputs perf_stall_cnt and perf_fwd_cnt (32b each).
//    perf_stall_cnt += 1 per hazard cycle.
//    perf_fwd_cnt += number of operands (0..4) taken from a bypass source in a non-stalled cycle.
//    Both counters hold under interlock, clear on rst and wrap modulo 2^32.
//  Undefined: no ports, no counters; remaining behaviour identical.
// STRUCTURE
//  core_pkg holds: word_t (XLEN), reg_idx_t (RIDX_W), localparam OP_LOAD = 6'b010000,
//    and function is_load(inst32).
//  Sub-module fwd_mux: one source index plus all producer buses -> operand and hit flag.
//    Instantiated 4x.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, stall_to_dec 0.
//  2. exec l_rt=5, flag=1, tdata=32'h1234; dec u_rs1=5 -> next cycle u_opa=32'h1234.
//     A gpr value 32'hDEAD is ignored.
//  3. Exec u_rt=7 (10) and l_rt=7 (20) both valid; source 7 -> operand 20 (lower wins).
//  4. inst_to_exec upper is a load with rt=3; dec l_rs2=3 -> stall_to_dec=1, bubble issued.
//     Next cycle mem_doutb[63:32]=32'hCAFE -> l_opb=32'hCAFE, valid=1.
//  5. interlock=1 for 3 cycles with changing inputs -> outputs frozen, counters unchanged.
//  6. PERF_EN: 4 hazard stalls and 6 bypassed operands -> stall_cnt=4, fwd_cnt=6.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the dual-issue operand-fetch stage.
// Word/index widths, load opcode and load detection.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [RIDX_W-1:0] reg_idx_t;

    localparam logic [5:0] OP_LOAD = 6'b010000;

    function automatic logic is_load(input logic [31:0] inst);
        return inst[31:26] == OP_LOAD;
    endfunction
endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector: picks the youngest matching producer, else the GPR read.
// hit reports that the operand came from a bypass path rather than the register file.
module fwd_mux
    import core_pkg::*;
(
    input  logic         src_flag,
    input  reg_idx_t     src,
    input  word_t        gpr_data,
    input  word_t        u_tdata_exec,
    input  word_t        l_tdata_exec,
    input  reg_idx_t     u_rt_exec,
    input  reg_idx_t     l_rt_exec,
    input  logic         u_rt_flag_exec,
    input  logic         l_rt_flag_exec,
    input  logic         u_load_exec,
    input  logic         l_load_exec,
    input  reg_idx_t     u_rt_mem,
    input  reg_idx_t     l_rt_mem,
    input  logic         u_rt_flag_mem,
    input  logic         l_rt_flag_mem,
    input  logic         u_load_mem,
    input  logic         l_load_mem,
    input  word_t        l_tdata_mem,
    input  logic [63:0]  mem_doutb,
    output word_t        operand,
    output logic         hit
);
    always_comb begin
        operand = gpr_data;
        hit     = 1'b0;
        if (src_flag) begin
            // Exec-stage loads have no data yet; those fall through to older producers.
            if (l_rt_flag_exec && !l_load_exec && l_rt_exec == src) begin
                operand = l_tdata_exec;
                hit     = 1'b1;
            end else if (u_rt_flag_exec && !u_load_exec && u_rt_exec == src) begin
                operand = u_tdata_exec;
                hit     = 1'b1;
            end else if (l_rt_flag_mem && l_rt_mem == src) begin
                operand = l_load_mem ? mem_doutb[31:0] : l_tdata_mem;
                hit     = 1'b1;
            end else if (u_rt_flag_mem && u_load_mem && u_rt_mem == src) begin
                // Upper non-load results already retired through exec; only loads bypass here.
                operand = mem_doutb[63:32];
                hit     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: GPR read, four-way bypass, load-use bubble, pipeline register to exec.
// Optional perf counters under OPERAND_FETCH_PERF_EN.
module operand_fetch
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  interlock,
    input  logic [63:0]           inst_from_dec,
    input  logic                  valid_from_dec,
    input  logic [2*RIDX_W-1:0]   u_rs_from_dec,
    input  logic [1:0]            u_rs_flag_from_dec,
    input  logic [2*RIDX_W-1:0]   l_rs_from_dec,
    input  logic [1:0]            l_rs_flag_from_dec,
    input  reg_idx_t              u_rt_from_dec,
    input  logic                  u_rt_flag_from_dec,
    input  reg_idx_t              l_rt_from_dec,
    input  logic                  l_rt_flag_from_dec,
    output logic [4*RIDX_W-1:0]   gpr_raddr,
    input  logic [4*XLEN-1:0]     gpr_rdata,
    input  word_t                 u_tdata_from_exec,
    input  word_t                 l_tdata_from_exec,
    input  reg_idx_t              u_rt_from_exec,
    input  reg_idx_t              l_rt_from_exec,
    input  logic                  u_rt_flag_from_exec,
    input  logic                  l_rt_flag_from_exec,
    input  logic [63:0]           inst_from_mem,
    input  reg_idx_t              u_rt_from_mem,
    input  reg_idx_t              l_rt_from_mem,
    input  logic                  u_rt_flag_from_mem,
    input  logic                  l_rt_flag_from_mem,
    input  word_t                 l_tdata_from_mem,
    input  logic [63:0]           mem_doutb,
    output logic                  stall_to_dec,
    output logic [63:0]           inst_to_exec,
    output logic                  valid_to_exec,
    output reg_idx_t              u_rt_to_exec,
    output logic                  u_rt_flag_to_exec,
    output reg_idx_t              l_rt_to_exec,
    output logic                  l_rt_flag_to_exec,
    output word_t                 u_opa_to_exec,
    output word_t                 u_opb_to_exec,
    output word_t                 l_opa_to_exec,
    output word_t                 l_opb_to_exec
`ifdef OPERAND_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_fwd_cnt
`endif
);
    reg_idx_t   src [4];
    logic [3:0] src_flag;
    word_t      op [4];
    logic [3:0] hit;
    logic       exec_u_load, exec_l_load, mem_u_load, mem_l_load;
    logic       hazard;

    // Operand order everywhere: 0 = u_rs1, 1 = u_rs2, 2 = l_rs1, 3 = l_rs2.
    assign src[0]   = u_rs_from_dec[2*RIDX_W-1:RIDX_W];
    assign src[1]   = u_rs_from_dec[RIDX_W-1:0];
    assign src[2]   = l_rs_from_dec[2*RIDX_W-1:RIDX_W];
    assign src[3]   = l_rs_from_dec[RIDX_W-1:0];
    assign src_flag = {l_rs_flag_from_dec[0], l_rs_flag_from_dec[1],
                       u_rs_flag_from_dec[0], u_rs_flag_from_dec[1]};
    assign gpr_raddr = {u_rs_from_dec, l_rs_from_dec};

    assign exec_u_load = is_load(inst_to_exec[63:32]);
    assign exec_l_load = is_load(inst_to_exec[31:0]);
    assign mem_u_load  = is_load(inst_from_mem[63:32]);
    assign mem_l_load  = is_load(inst_from_mem[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_fwd
        fwd_mux u_fwd (
            .src            (src[i]),
            .src_flag       (src_flag[i]),
            .gpr_data       (gpr_rdata[4*XLEN-1-i*XLEN -: XLEN]),
            .u_tdata_exec   (u_tdata_from_exec),
            .l_tdata_exec   (l_tdata_from_exec),
            .u_rt_exec      (u_rt_from_exec),
            .l_rt_exec      (l_rt_from_exec),
            .u_rt_flag_exec (u_rt_flag_from_exec),
            .l_rt_flag_exec (l_rt_flag_from_exec),
            .u_load_exec    (exec_u_load),
            .l_load_exec    (exec_l_load),
            .u_rt_mem       (u_rt_from_mem),
            .l_rt_mem       (l_rt_from_mem),
            .u_rt_flag_mem  (u_rt_flag_from_mem),
            .l_rt_flag_mem  (l_rt_flag_from_mem),
            .u_load_mem     (mem_u_load),
            .l_load_mem     (mem_l_load),
            .l_tdata_mem    (l_tdata_from_mem),
            .mem_doutb      (mem_doutb),
            .operand        (op[i]),
            .hit            (hit[i])
        );
    end

    always_comb begin
        hazard = 1'b0;
        if (valid_to_exec && valid_from_dec) begin
            for (int i = 0; i < 4; i++) begin
                if (src_flag[i]) begin
                    if (exec_u_load && u_rt_flag_to_exec && u_rt_to_exec == src[i]) hazard = 1'b1;
                    if (exec_l_load && l_rt_flag_to_exec && l_rt_to_exec == src[i]) hazard = 1'b1;
                end
            end
        end
    end

    assign stall_to_dec = hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_to_exec      <= '0;
            valid_to_exec     <= 1'b0;
            u_rt_to_exec      <= '0;
            u_rt_flag_to_exec <= 1'b0;
            l_rt_to_exec      <= '0;
            l_rt_flag_to_exec <= 1'b0;
            u_opa_to_exec     <= '0;
            u_opb_to_exec     <= '0;
            l_opa_to_exec     <= '0;
            l_opb_to_exec     <= '0;
        end else if (!interlock) begin
            if (hazard) begin
                inst_to_exec      <= '0;
                valid_to_exec     <= 1'b0;
                u_rt_to_exec      <= '0;
                u_rt_flag_to_exec <= 1'b0;
                l_rt_to_exec      <= '0;
                l_rt_flag_to_exec <= 1'b0;
                u_opa_to_exec     <= '0;
                u_opb_to_exec     <= '0;
                l_opa_to_exec     <= '0;
                l_opb_to_exec     <= '0;
            end else begin
                inst_to_exec      <= inst_from_dec;
                valid_to_exec     <= valid_from_dec;
                u_rt_to_exec      <= u_rt_from_dec;
                u_rt_flag_to_exec <= u_rt_flag_from_dec;
                l_rt_to_exec      <= l_rt_from_dec;
                l_rt_flag_to_exec <= l_rt_flag_from_dec;
                u_opa_to_exec     <= op[0];
                u_opb_to_exec     <= op[1];
                l_opa_to_exec     <= op[2];
                l_opb_to_exec     <= op[3];
            end
        end
    end

`ifdef OPERAND_FETCH_PERF_EN
    logic [2:0] n_hit;

    always_comb begin
        n_hit = '0;
        for (int i = 0; i < 4; i++) n_hit = n_hit + {2'b00, hit[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (!interlock) begin
            if (hazard) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            else        perf_fwd_cnt   <= perf_fwd_cnt + {29'd0, n_hit};
        end
    end
`else
    logic unused_hit;
    assign unused_hit = |hit;
`endif
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: bypass vector table, load-use bubble, interlock hold.
// Perf counter checks are compiled when OPERAND_FETCH_PERF_EN is defined.
module tb_operand_fetch;
    logic         clk, rst, interlock;
    logic [63:0]  inst_from_dec;
    logic         valid_from_dec;
    logic [9:0]   u_rs_from_dec, l_rs_from_dec;
    logic [1:0]   u_rs_flag_from_dec, l_rs_flag_from_dec;
    logic [4:0]   u_rt_from_dec, l_rt_from_dec;
    logic         u_rt_flag_from_dec, l_rt_flag_from_dec;
    logic [19:0]  gpr_raddr;
    logic [127:0] gpr_rdata;
    logic [31:0]  u_tdata_from_exec, l_tdata_from_exec;
    logic [4:0]   u_rt_from_exec, l_rt_from_exec;
    logic         u_rt_flag_from_exec, l_rt_flag_from_exec;
    logic [63:0]  inst_from_mem;
    logic [4:0]   u_rt_from_mem, l_rt_from_mem;
    logic         u_rt_flag_from_mem, l_rt_flag_from_mem;
    logic [31:0]  l_tdata_from_mem;
    logic [63:0]  mem_doutb;
    logic         stall_to_dec;
    logic [63:0]  inst_to_exec;
    logic         valid_to_exec;
    logic [4:0]   u_rt_to_exec, l_rt_to_exec;
    logic         u_rt_flag_to_exec, l_rt_flag_to_exec;
    logic [31:0]  u_opa_to_exec, u_opb_to_exec, l_opa_to_exec, l_opb_to_exec;
`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0]  perf_stall_cnt, perf_fwd_cnt;
`endif

    operand_fetch dut (
        .clk(clk), .rst(rst), .interlock(interlock),
        .inst_from_dec(inst_from_dec), .valid_from_dec(valid_from_dec),
        .u_rs_from_dec(u_rs_from_dec), .u_rs_flag_from_dec(u_rs_flag_from_dec),
        .l_rs_from_dec(l_rs_from_dec), .l_rs_flag_from_dec(l_rs_flag_from_dec),
        .u_rt_from_dec(u_rt_from_dec), .u_rt_flag_from_dec(u_rt_flag_from_dec),
        .l_rt_from_dec(l_rt_from_dec), .l_rt_flag_from_dec(l_rt_flag_from_dec),
        .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
        .u_tdata_from_exec(u_tdata_from_exec), .l_tdata_from_exec(l_tdata_from_exec),
        .u_rt_from_exec(u_rt_from_exec), .l_rt_from_exec(l_rt_from_exec),
        .u_rt_flag_from_exec(u_rt_flag_from_exec), .l_rt_flag_from_exec(l_rt_flag_from_exec),
        .inst_from_mem(inst_from_mem),
        .u_rt_from_mem(u_rt_from_mem), .l_rt_from_mem(l_rt_from_mem),
        .u_rt_flag_from_mem(u_rt_flag_from_mem), .l_rt_flag_from_mem(l_rt_flag_from_mem),
        .l_tdata_from_mem(l_tdata_from_mem), .mem_doutb(mem_doutb),
        .stall_to_dec(stall_to_dec),
        .inst_to_exec(inst_to_exec), .valid_to_exec(valid_to_exec),
        .u_rt_to_exec(u_rt_to_exec), .u_rt_flag_to_exec(u_rt_flag_to_exec),
        .l_rt_to_exec(l_rt_to_exec), .l_rt_flag_to_exec(l_rt_flag_to_exec),
        .u_opa_to_exec(u_opa_to_exec), .u_opb_to_exec(u_opb_to_exec),
        .l_opa_to_exec(l_opa_to_exec), .l_opb_to_exec(l_opb_to_exec)
`ifdef OPERAND_FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    localparam logic [63:0] INST_ALU  = 64'h0400_0001_0800_0002;
    localparam logic [63:0] INST_LD_U = 64'h4000_0003_0800_0002;
    localparam logic [63:0] INST_LD_L = 64'h0400_0001_4000_0005;
    localparam logic [63:0] LD_BOTH   = 64'h4000_0000_4000_0000;

    typedef struct packed {
        logic [63:0]  inst;
        logic         valid;
        logic [19:0]  rs;
        logic [3:0]   rsf;
        logic [4:0]   u_rt, l_rt;
        logic [4:0]   eu_rt;  logic eu_f; logic [31:0] eu_d;
        logic [4:0]   el_rt;  logic el_f; logic [31:0] el_d;
        logic [63:0]  mem_inst;
        logic [4:0]   mu_rt;  logic mu_f;
        logic [4:0]   ml_rt;  logic ml_f; logic [31:0] ml_d;
        logic [63:0]  doutb;
        logic [127:0] exp_ops;
    } vec_t;

    typedef struct packed {
        logic [63:0]  inst;
        logic         valid;
        logic [4:0]   u_rt;  logic u_f;
        logic [4:0]   l_rt;  logic l_f;
        logic [127:0] ops;
        logic         chk_ops;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[9];

    // Register-file model: every register reads back a tagged value of its own index.
    function automatic logic [31:0] gv(input logic [4:0] i);
        return 32'hA5A5_0000 + {27'd0, i};
    endfunction

    always_comb gpr_rdata = {gv(gpr_raddr[19:15]), gv(gpr_raddr[14:10]),
                             gv(gpr_raddr[9:5]), gv(gpr_raddr[4:0])};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t base(input int k);
        vec_t v;
        v         = '0;
        v.inst    = INST_ALU;
        v.valid   = 1'b1;
        v.rs      = {5'd1, 5'd2, 5'd3, 5'd4};
        v.rsf     = 4'hF;
        v.u_rt    = 5'(k + 1);
        v.l_rt    = 5'(k + 20);
        v.mem_inst = INST_ALU;
        v.exp_ops = {gv(1), gv(2), gv(3), gv(4)};
        return v;
    endfunction

    function automatic exp_t exp_from_vec(input vec_t v);
        exp_t e;
        e.inst = v.inst; e.valid = v.valid;
        e.u_rt = v.u_rt; e.u_f = 1'b1;
        e.l_rt = v.l_rt; e.l_f = 1'b1;
        e.ops = v.exp_ops; e.chk_ops = 1'b1;
        return e;
    endfunction

    task automatic drive_vec(input vec_t v);
        inst_from_dec       = v.inst;
        valid_from_dec      = v.valid;
        u_rs_from_dec       = v.rs[19:10];
        l_rs_from_dec       = v.rs[9:0];
        u_rs_flag_from_dec  = v.rsf[3:2];
        l_rs_flag_from_dec  = v.rsf[1:0];
        u_rt_from_dec       = v.u_rt;  u_rt_flag_from_dec = 1'b1;
        l_rt_from_dec       = v.l_rt;  l_rt_flag_from_dec = 1'b1;
        u_rt_from_exec      = v.eu_rt; u_rt_flag_from_exec = v.eu_f; u_tdata_from_exec = v.eu_d;
        l_rt_from_exec      = v.el_rt; l_rt_flag_from_exec = v.el_f; l_tdata_from_exec = v.el_d;
        inst_from_mem       = v.mem_inst;
        u_rt_from_mem       = v.mu_rt; u_rt_flag_from_mem = v.mu_f;
        l_rt_from_mem       = v.ml_rt; l_rt_flag_from_mem = v.ml_f;
        l_tdata_from_mem    = v.ml_d;
        mem_doutb           = v.doutb;
    endtask

    task automatic compare_exp(input string name, input exp_t e);
        check({name, ".inst"},  128'(inst_to_exec), 128'(e.inst));
        check({name, ".valid"}, 128'(valid_to_exec), 128'(e.valid));
        check({name, ".flags"}, 128'({u_rt_flag_to_exec, l_rt_flag_to_exec}), 128'({e.u_f, e.l_f}));
        if (e.chk_ops) begin
            check({name, ".rt"}, 128'({u_rt_to_exec, l_rt_to_exec}), 128'({e.u_rt, e.l_rt}));
            check({name, ".ops"}, {u_opa_to_exec, u_opb_to_exec, l_opa_to_exec, l_opb_to_exec}, e.ops);
        end
    endtask

    task automatic pop_compare(input string name);
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty, got output with no expectation", name);
        end else begin
            compare_exp(name, sb.pop_front());
        end
    endtask

    // Load in exec, dependent bundle stalls one cycle, then resumes with the load data from mem.
    task automatic load_use();
        vec_t v;
        exp_t e;
        @(negedge clk);
        v = base(0); v.inst = INST_LD_U; v.u_rt = 5'd3;
        v.rs = {5'd1, 5'd2, 5'd4, 5'd6};
        v.exp_ops = {gv(1), gv(2), gv(4), gv(6)};
        drive_vec(v); #1;
        check("lu_stall_load", 128'(stall_to_dec), 128'(0));
        sb.push_back(exp_from_vec(v));
        @(posedge clk); #1 pop_compare("lu_load");
        @(negedge clk);
        v = base(1); v.rs = {5'd1, 5'd2, 5'd4, 5'd3};
        v.exp_ops = {gv(1), gv(2), gv(4), 32'h0000_CAFE};
        drive_vec(v); #1;
        check("lu_stall_dep", 128'(stall_to_dec), 128'(1));
        e = '0;
        sb.push_back(e);
        @(posedge clk); #1 pop_compare("lu_bubble");
        @(negedge clk);
        v.mem_inst = INST_LD_U; v.mu_rt = 5'd3; v.mu_f = 1'b1;
        v.doutb = {32'h0000_CAFE, 32'h0000_0BAD};
        drive_vec(v); #1;
        check("lu_stall_resume", 128'(stall_to_dec), 128'(0));
        sb.push_back(exp_from_vec(v));
        @(posedge clk); #1 pop_compare("lu_resume");
    endtask

    initial begin
        vec_t v;
        exp_t e, e_hold;

        vecs[0] = base(0);
        vecs[1] = base(1); vecs[1].rs = {5'd5, 5'd6, 5'd7, 5'd8};
        vecs[1].el_rt = 5'd5; vecs[1].el_f = 1'b1; vecs[1].el_d = 32'h1234;
        vecs[1].exp_ops = {32'h1234, gv(6), gv(7), gv(8)};
        vecs[2] = base(2); vecs[2].rs = {5'd9, 5'd7, 5'd7, 5'd10};
        vecs[2].eu_rt = 5'd7; vecs[2].eu_f = 1'b1; vecs[2].eu_d = 32'd10;
        vecs[2].el_rt = 5'd7; vecs[2].el_f = 1'b1; vecs[2].el_d = 32'd20;
        vecs[2].exp_ops = {gv(9), 32'd20, 32'd20, gv(10)};
        vecs[3] = base(3); vecs[3].rs = {5'd12, 5'd1, 5'd2, 5'd11};
        vecs[3].eu_rt = 5'd11; vecs[3].eu_f = 1'b1; vecs[3].eu_d = 32'h111;
        vecs[3].ml_rt = 5'd11; vecs[3].ml_f = 1'b1; vecs[3].ml_d = 32'h222;
        vecs[3].exp_ops = {gv(12), gv(1), gv(2), 32'h111};
        vecs[4] = base(4); vecs[4].rs = {5'd13, 5'd14, 5'd15, 5'd13};
        vecs[4].ml_rt = 5'd13; vecs[4].ml_f = 1'b1; vecs[4].ml_d = 32'h333;
        vecs[4].mu_rt = 5'd14; vecs[4].mu_f = 1'b1;
        vecs[4].exp_ops = {32'h333, gv(14), gv(15), 32'h333};
        vecs[5] = base(5); vecs[5].rs = {5'd16, 5'd17, 5'd16, 5'd18};
        vecs[5].mem_inst = LD_BOTH;
        vecs[5].mu_rt = 5'd16; vecs[5].mu_f = 1'b1; vecs[5].ml_rt = 5'd17; vecs[5].ml_f = 1'b1;
        vecs[5].doutb = {32'hCAFE_0001, 32'hBEEF_0002};
        vecs[5].exp_ops = {32'hCAFE_0001, 32'hBEEF_0002, 32'hCAFE_0001, gv(18)};
        vecs[6] = base(6); vecs[6].rs = {5'd19, 5'd1, 5'd2, 5'd19};
        vecs[6].mem_inst = LD_BOTH;
        vecs[6].mu_rt = 5'd19; vecs[6].mu_f = 1'b1; vecs[6].ml_rt = 5'd19; vecs[6].ml_f = 1'b1;
        vecs[6].doutb = {32'h1111_0000, 32'h2222_0000};
        vecs[6].exp_ops = {32'h2222_0000, gv(1), gv(2), 32'h2222_0000};
        vecs[7] = base(7); vecs[7].rs = {5'd20, 5'd21, 5'd22, 5'd23}; vecs[7].rsf = 4'b0111;
        vecs[7].el_rt = 5'd20; vecs[7].el_f = 1'b1; vecs[7].el_d = 32'h55;
        vecs[7].eu_rt = 5'd21; vecs[7].eu_f = 1'b0; vecs[7].eu_d = 32'h56;
        vecs[7].exp_ops = {gv(20), gv(21), gv(22), gv(23)};
        vecs[8] = base(8); vecs[8].rs = {5'd0, 5'd24, 5'd25, 5'd26};
        vecs[8].el_rt = 5'd0; vecs[8].el_f = 1'b1; vecs[8].el_d = 32'h66;
        vecs[8].eu_rt = 5'd24; vecs[8].eu_f = 1'b1; vecs[8].eu_d = 32'h77;
        vecs[8].exp_ops = {32'h66, 32'h77, gv(25), gv(26)};

        v = '0; v.mem_inst = '0;
        drive_vec(v);
        valid_from_dec = 1'b0; u_rt_flag_from_dec = 1'b0; l_rt_flag_from_dec = 1'b0;
        interlock = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e = '0; e.chk_ops = 1'b1;
        compare_exp("reset", e);
        check("reset.stall", 128'(stall_to_dec), 128'(0));
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive_vec(vecs[k]); #1;
            check($sformatf("tbl%0d.stall", k), 128'(stall_to_dec), 128'(0));
            check($sformatf("tbl%0d.raddr", k), 128'(gpr_raddr), 128'(vecs[k].rs));
            sb.push_back(exp_from_vec(vecs[k]));
            @(posedge clk); #1 pop_compare($sformatf("tbl%0d", k));
        end

        load_use();

        // Lower-lane load in exec: stalls a valid consumer, but not an invalid one,
        // and its own exec result must never be bypassed.
        @(negedge clk);
        v = base(2); v.inst = INST_LD_L; v.l_rt = 5'd8;
        drive_vec(v); #1;
        check("ldl_stall_load", 128'(stall_to_dec), 128'(0));
        sb.push_back(exp_from_vec(v));
        @(posedge clk); #1 pop_compare("ldl_load");
        @(negedge clk);
        v = base(3); v.rs = {5'd8, 5'd1, 5'd2, 5'd3};
        v.el_rt = 5'd8; v.el_f = 1'b1; v.el_d = 32'h999;
        v.ml_rt = 5'd8; v.ml_f = 1'b1; v.ml_d = 32'h777;
        drive_vec(v); #1;
        check("ldl_stall_valid", 128'(stall_to_dec), 128'(1));
        valid_from_dec = 1'b0; #1;
        check("ldl_stall_invalid", 128'(stall_to_dec), 128'(0));
        v.valid = 1'b0;
        v.exp_ops = {32'h777, gv(1), gv(2), gv(3)};
        sb.push_back(exp_from_vec(v));
        @(posedge clk); #1 pop_compare("exec_load_skip");

        // Interlock: everything registered must hold while inputs keep changing.
        @(negedge clk);
        drive_vec(vecs[1]);
        e_hold = exp_from_vec(vecs[1]);
        sb.push_back(e_hold);
        @(posedge clk); #1 pop_compare("pre_ilk");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            interlock = 1'b1;
            drive_vec(vecs[2 + i]);
            u_tdata_from_exec = $urandom;
            @(posedge clk); #1 compare_exp($sformatf("ilk%0d", i), e_hold);
        end
        @(negedge clk) interlock = 1'b0;

`ifdef OPERAND_FETCH_PERF_EN
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("perf_rst_stall", 128'(perf_stall_cnt), 128'(0));
        check("perf_rst_fwd", 128'(perf_fwd_cnt), 128'(0));
        @(negedge clk) rst = 1'b0;
        v = '0; drive_vec(v); valid_from_dec = 1'b0;
        for (int i = 0; i < 4; i++) load_use();
        @(negedge clk);
        v = base(5); v.rs = {5'd5, 5'd6, 5'd1, 5'd2};
        v.el_rt = 5'd5; v.el_f = 1'b1; v.el_d = 32'h11;
        v.eu_rt = 5'd6; v.eu_f = 1'b1; v.eu_d = 32'h22;
        v.exp_ops = {32'h11, 32'h22, gv(1), gv(2)};
        drive_vec(v);
        sb.push_back(exp_from_vec(v));
        @(posedge clk); #1 pop_compare("perf_fwd2");
        check("perf_stall_cnt", 128'(perf_stall_cnt), 128'(4));
        check("perf_fwd_cnt", 128'(perf_fwd_cnt), 128'(6));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            interlock = 1'b1;
            drive_vec(vecs[1 + i]);
            @(posedge clk); #1;
            check($sformatf("perf_ilk%0d_stall", i), 128'(perf_stall_cnt), 128'(4));
            check($sformatf("perf_ilk%0d_fwd", i), 128'(perf_fwd_cnt), 128'(6));
        end
        @(negedge clk) interlock = 1'b0;
`endif

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
